// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline latch with stall/flush, 32x32 register file with
// write-to-read bypass, and combinational operand/immediate/target decode.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [31:0] instruction_in,
    input  logic [23:0] bundle_in,
    input  logic [31:0] pc_seq_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic [31:0] instruction_out,
    output logic [23:0] bundle_out,
    output logic [31:0] pc_seq_out,
    output logic [4:0]  rs_addr_out,
    output logic [4:0]  rt_addr_out,
    output logic [4:0]  rd_addr_out,
    output logic [4:0]  shamt_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_sext_out,
    output logic [31:0] imm_zext_out,
    output logic [31:0] branch_target_out,
    output logic [31:0] jump_target_out,
    output logic        regs_eq_out
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BUNDLE_W  = 24;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [XLEN-1:0]     NOP_INSTR  = 32'h3400_0000;
    localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = 24'h0E_2531;
    localparam logic [XLEN-1:0]     RESET_PC   = 32'h0040_0004;

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wb_hit;

    // IF/ID latch: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (!reset) begin
            instruction_out <= NOP_INSTR;
            bundle_out      <= NOP_BUNDLE;
            pc_seq_out      <= RESET_PC;
        end else if (flush_in) begin
            instruction_out <= NOP_INSTR;
            bundle_out      <= NOP_BUNDLE;
            pc_seq_out      <= pc_seq_in;
        end else if (!stall_in) begin
            instruction_out <= instruction_in;
            bundle_out      <= bundle_in;
            pc_seq_out      <= pc_seq_in;
        end
    end

    // Register file; writes ignore stall/flush but not reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_addr_in] <= wb_data_in;
        end
    end

    assign wb_hit = wb_en_in && (wb_addr_in != '0);

    function automatic logic [XLEN-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
        logic [XLEN-1:0] val;
        val = regs[idx];
        if (idx == '0) begin
            val = '0;
        end else if (wb_hit && (wb_addr_in == idx)) begin
            val = wb_data_in;
        end
        return val;
    endfunction

    assign rs_addr_out = instruction_out[25:21];
    assign rt_addr_out = instruction_out[20:16];
    assign rd_addr_out = instruction_out[15:11];
    assign shamt_out   = instruction_out[10:6];

    always_comb begin
        rs_data_out = read_port(rs_addr_out);
        rt_data_out = read_port(rt_addr_out);
    end

    assign regs_eq_out       = (rs_data_out == rt_data_out);
    assign imm_sext_out      = {{16{instruction_out[15]}}, instruction_out[15:0]};
    assign imm_zext_out      = {16'h0000, instruction_out[15:0]};
    assign branch_target_out = pc_seq_out + {imm_sext_out[29:0], 2'b00};
    assign jump_target_out   = {pc_seq_out[31:28], instruction_out[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: constant vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] instruction_in;
    logic [23:0] bundle_in;
    logic [31:0] pc_seq_in;
    logic        wb_en_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic [31:0] instruction_out;
    logic [23:0] bundle_out;
    logic [31:0] pc_seq_out;
    logic [4:0]  rs_addr_out, rt_addr_out, rd_addr_out, shamt_out;
    logic [31:0] rs_data_out, rt_data_out;
    logic [31:0] imm_sext_out, imm_zext_out;
    logic [31:0] branch_target_out, jump_target_out;
    logic        regs_eq_out;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .instruction_in(instruction_in), .bundle_in(bundle_in), .pc_seq_in(pc_seq_in),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .instruction_out(instruction_out), .bundle_out(bundle_out), .pc_seq_out(pc_seq_out),
        .rs_addr_out(rs_addr_out), .rt_addr_out(rt_addr_out), .rd_addr_out(rd_addr_out),
        .shamt_out(shamt_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .imm_sext_out(imm_sext_out), .imm_zext_out(imm_zext_out),
        .branch_target_out(branch_target_out), .jump_target_out(jump_target_out),
        .regs_eq_out(regs_eq_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_instr, m_pc;
    logic [23:0] m_bundle;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0) return 32'h0;
        if (wb_en_in && int'(wb_addr_in) == idx) return wb_data_in;
        return m_regs[idx];
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_instr  = 32'h3400_0000;
            m_bundle = 24'h0E2531;
            m_pc     = 32'h0040_0004;
            foreach (m_regs[i]) m_regs[i] = 32'h0;
        end else begin
            if (flush_in) begin
                m_instr  = 32'h3400_0000;
                m_bundle = 24'h0E2531;
                m_pc     = pc_seq_in;
            end else if (!stall_in) begin
                m_instr  = instruction_in;
                m_bundle = bundle_in;
                m_pc     = pc_seq_in;
            end
            if (wb_en_in && wb_addr_in != 5'd0) m_regs[wb_addr_in] = wb_data_in;
        end
    endtask

    task automatic check_all();
        int rs, rt;
        logic [31:0] sx, a, b;
        rs = int'(m_instr / 32'h0020_0000) % 32;
        rt = int'(m_instr / 32'h0001_0000) % 32;
        sx = 32'($signed(m_instr[15:0]));
        a  = m_read(rs);
        b  = m_read(rt);
        chk("instruction", instruction_out, m_instr);
        chk("bundle", 32'(bundle_out), 32'(m_bundle));
        chk("pc_seq", pc_seq_out, m_pc);
        chk("rs_addr", 32'(rs_addr_out), 32'(rs));
        chk("rt_addr", 32'(rt_addr_out), 32'(rt));
        chk("rd_addr", 32'(rd_addr_out), (m_instr / 32'h800) % 32);
        chk("shamt", 32'(shamt_out), (m_instr / 32'h40) % 32);
        chk("rs_data", rs_data_out, a);
        chk("rt_data", rt_data_out, b);
        chk("imm_sext", imm_sext_out, sx);
        chk("imm_zext", imm_zext_out, m_instr % 32'h1_0000);
        chk("branch_target", branch_target_out, m_pc + sx * 4);
        chk("jump_target", jump_target_out, (m_pc & 32'hF000_0000) | ((m_instr % 32'h0400_0000) * 4));
        chk("regs_eq", 32'(regs_eq_out), 32'(a == b));
    endtask

    // Advance one clock; inputs change only #1 after the rising edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] sext, zext, br, jmp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h1022FFFE, 32'h00400010, 5'd1,  5'd2,  5'd31, 5'd31,
                    32'hFFFFFFFE, 32'h0000FFFE, 32'h00400008, 32'h008BFFF8};
        vecs[1] = '{32'h0BFFFFFF, 32'hFFFFFFFC, 5'd31, 5'd31, 5'd31, 5'd31,
                    32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFF8, 32'hFFFFFFFC};
        vecs[2] = '{32'h10000001, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd0,  5'd0,
                    32'h00000001, 32'h00000001, 32'h00000000, 32'hF0000004};
        vecs[3] = '{32'h8C220004, 32'h00400020, 5'd1,  5'd2,  5'd0,  5'd0,
                    32'h00000004, 32'h00000004, 32'h00400030, 32'h00880010};
        vecs[4] = '{32'h00A41940, 32'h12345678, 5'd5,  5'd4,  5'd3,  5'd5,
                    32'h00001940, 32'h00001940, 32'h1234BB78, 32'h12906500};

        // Reset for two cycles with random inputs (including writes)
        reset = 1'b0; stall_in = 1'($urandom); flush_in = 1'($urandom);
        instruction_in = $urandom; bundle_in = 24'($urandom); pc_seq_in = $urandom;
        wb_en_in = 1'b1; wb_addr_in = 5'd7; wb_data_in = $urandom;
        tick();
        instruction_in = $urandom; wb_addr_in = 5'd9; stall_in = 1'b1;
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("rst_instruction", instruction_out, 32'h34000000);
        chk("rst_bundle", 32'(bundle_out), 32'h000E2531);
        chk("rst_pc_seq", pc_seq_out, 32'h00400004);
        chk("rst_rs_data", rs_data_out, 32'h0);
        chk("rst_regs_eq", 32'(regs_eq_out), 32'h1);
        chk("rst_imm_sext", imm_sext_out, 32'h0);
        chk("rst_imm_zext", imm_zext_out, 32'h0);
        chk("rst_branch", branch_target_out, 32'h00400004);
        chk("rst_jump", jump_target_out, 32'h0);

        // Every register reads zero after reset
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            instruction_in = (32'(i) << 21) | (32'(31 - i) << 16);
            tick();
            chk("sweep_rs_data", rs_data_out, 32'h0);
            chk("sweep_rt_data", rt_data_out, 32'h0);
        end

        // Table-driven decode checks (register file still all zero)
        for (int v = 0; v < 5; v++) begin
            instruction_in = vecs[v].instr; pc_seq_in = vecs[v].pc; bundle_in = 24'($urandom);
            tick();
            chk("vec_rs_addr", 32'(rs_addr_out), 32'(vecs[v].rs));
            chk("vec_rt_addr", 32'(rt_addr_out), 32'(vecs[v].rt));
            chk("vec_rd_addr", 32'(rd_addr_out), 32'(vecs[v].rd));
            chk("vec_shamt", 32'(shamt_out), 32'(vecs[v].sh));
            chk("vec_imm_sext", imm_sext_out, vecs[v].sext);
            chk("vec_imm_zext", imm_zext_out, vecs[v].zext);
            chk("vec_branch", branch_target_out, vecs[v].br);
            chk("vec_jump", jump_target_out, vecs[v].jmp);
            chk("vec_regs_eq", 32'(regs_eq_out), 32'h1);
        end

        // Writeback with same-cycle bypass, then persistence from the array
        instruction_in = 32'h00600000;
        tick();
        wb_en_in = 1'b1; wb_addr_in = 5'd3; wb_data_in = 32'hDEADBEEF;
        #1;
        chk("bypass_same_cycle", rs_data_out, 32'hDEADBEEF);
        chk("bypass_regs_eq", 32'(regs_eq_out), 32'h0);
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("wb_persist", rs_data_out, 32'hDEADBEEF);

        // $0 is never written and never bypassed
        instruction_in = 32'h00000000;
        tick();
        wb_en_in = 1'b1; wb_addr_in = 5'd0; wb_data_in = 32'h12345678;
        #1;
        chk("zero_rs_same", rs_data_out, 32'h0);
        chk("zero_rt_same", rt_data_out, 32'h0);
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("zero_rs_after", rs_data_out, 32'h0);

        // Stall holds for three cycles, then flush beats stall
        instruction_in = 32'h8C220004; bundle_in = 24'hABCDEF; pc_seq_in = 32'h00400020;
        tick();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instruction_in = $urandom; bundle_in = 24'($urandom); pc_seq_in = $urandom;
            tick();
            chk("stall_instruction", instruction_out, 32'h8C220004);
            chk("stall_bundle", 32'(bundle_out), 32'h00ABCDEF);
            chk("stall_pc_seq", pc_seq_out, 32'h00400020);
        end
        flush_in = 1'b1; pc_seq_in = 32'h00500000;
        tick();
        chk("flush_instruction", instruction_out, 32'h34000000);
        chk("flush_bundle", 32'(bundle_out), 32'h000E2531);
        chk("flush_pc_seq", pc_seq_out, 32'h00500000);

        // Reset during stall+flush wins; loading resumes right after
        reset = 1'b0;
        tick();
        chk("rst_mid_pc_seq", pc_seq_out, 32'h00400004);
        chk("rst_mid_clears", rs_data_out | rt_data_out, 32'h0);
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        instruction_in = 32'h00A41940; pc_seq_in = 32'h12345678;
        tick();
        chk("resume_instruction", instruction_out, 32'h00A41940);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 39) != 0);
            stall_in = ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 7) == 0);
            instruction_in = $urandom;
            instruction_in[25:21] = 5'($urandom_range(0, 7));
            instruction_in[20:16] = 5'($urandom_range(0, 7));
            bundle_in  = 24'($urandom);
            pc_seq_in  = $urandom;
            wb_en_in   = 1'($urandom);
            wb_addr_in = 5'($urandom_range(0, 7));
            wb_data_in = ($urandom_range(0, 3) == 0) ? m_regs[$urandom_range(0, 7)] : $urandom;
            #1;
            check_all();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage, directly downstream of the fetch stage. Captures the fetched instruction, its 24-bit control bundle and sequential PC in an IF/ID latch with stall and flush control. Holds the 32×32 architectural register file, with a writeback port and write-to-read bypass. Produces operand data, extended immediates, branch/jump targets and a register-equality flag for the execute stage.

## Interface
- NOP_INSTR, 32'h34000000, instruction injected on flush/reset (ori $zero,$zero,0)
- NOP_BUNDLE, 24'h0E2531, control bundle injected with NOP_INSTR
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- stall_in  in  1  hold IF/ID latch contents
- flush_in  in  1  replace latch contents with NOP
- instruction_in  in  32  instruction from fetch
- bundle_in  in  24  control bundle from fetch
- pc_seq_in  in  32  PC+4 from fetch
- wb_en_in  in  1  register-file write enable
- wb_addr_in  in  5  write register index
- wb_data_in  in  32  write data
- instruction_out  out  32  latched instruction
- bundle_out  out  24  latched bundle
- pc_seq_out  out  32  latched PC+4
- rs_addr_out / rt_addr_out / rd_addr_out  out  5 each  instr[25:21] / [20:16] / [15:11]
- shamt_out  out  5  instr[10:6]
- rs_data_out / rt_data_out  out  32 each  operand values, bypassed
- imm_sext_out  out  32  sign-extended instr[15:0]
- imm_zext_out  out  32  zero-extended instr[15:0]
- branch_target_out  out  32  pc_seq_out + (imm_sext_out << 2), mod 2^32
- jump_target_out  out  32  {pc_seq_out[31:28], instr[25:0], 2'b00}
- regs_eq_out  out  1  rs_data_out == rt_data_out

## Operation
- IF/ID latch update at each rising edge, priority order:
  - reset low: instruction = NOP_INSTR, bundle = NOP_BUNDLE, pc_seq = 32'h00400004.
  - else flush_in: same NOP/bundle; pc_seq_out loads pc_seq_in.
  - else stall_in: all three fields hold.
  - else load instruction_in, bundle_in, pc_seq_in.
- flush_in and stall_in both high: flush wins.
- Register file:
  - 32 entries × 32 bits; reset low clears all entries to 0.
  - Write at the rising edge when wb_en_in=1 and wb_addr_in≠0.
  - $0 always reads 0; writes to it are discarded.
  - Writes proceed regardless of stall_in/flush_in. reset low suppresses the write in that cycle.
- Read ports are combinational, indexed by the latched instruction's rs/rt fields.
- Bypass: if wb_en_in=1, wb_addr_in≠0 and wb_addr_in equals the port index, the port returns wb_data_in instead of the array value.
- All decoded fields, extensions, targets and regs_eq_out are combinational from latch, register-file and bypass state.
- Arithmetic:
  - branch_target_out wraps modulo 2^32.
  - Sign extension replicates instr[15].
  - Zero extension pads with zeros.

## Timing
- Latency: fetch outputs present before edge N appear on instruction_out/bundle_out/pc_seq_out after edge N.
- Derived outputs are valid in the same cycle, with no extra register stage.
- A write presented in cycle N is visible combinationally in cycle N via the bypass, and from the array from cycle N+1.
- Reset values after the first edge with reset low:
  - instruction_out 32'h34000000, bundle_out 24'h0E2531, pc_seq_out 32'h00400004.
  - rs/rt data 0, regs_eq_out 1, imm outputs 0.
  - branch_target_out 32'h00400004, jump_target_out 32'h00000000.
- Reset asserted mid-stall or mid-flush: reset takes priority in that cycle. Normal loading resumes on the first edge after reset returns high, unless stall_in/flush_in is high.
- Stall held for k cycles keeps outputs constant for k cycles, except rs/rt data, which track register-file writes and bypass.

## Test plan
- Reset: hold reset low 2 cycles with random inputs -> instruction_out 0x34000000, bundle_out 0x0E2531, pc_seq_out 0x00400004; every register reads 0.
- Load and decode: instruction_in 0x1022FFFE (beq $1,$2,-2), pc_seq_in 0x00400010 -> next cycle rs_addr 1, rt_addr 2, imm_sext 0xFFFFFFFE, imm_zext 0x0000FFFE, branch_target 0x00400008, regs_eq 1 (both zero).
- Writeback and bypass: latch has rs=$3; drive wb_en=1, wb_addr=3, wb_data 0xDEADBEEF -> rs_data_out 0xDEADBEEF in the same cycle, and it persists after wb_en drops.
- $0 protection: write 0x12345678 to register 0 -> rs/rt reading $0 return 0, both in the same cycle and afterwards.
- Stall/flush priority: load 0x8C220004; stall 3 cycles with changing inputs -> outputs held. Then assert stall and flush together -> NOP_INSTR/NOP_BUNDLE latched, and pc_seq_out loads pc_seq_in.
- Jump and wrap: pc_seq_in 0xFFFFFFFC with instr 0x0BFFFFFF -> jump_target 0xFFFFFFFC. Instr 0x10000001 -> branch_target 0x00000000 (wrap).
